// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//   Integer register file for the decode stage: NUM_READ registered read ports
//   and one write port driven from writeback. After reset a clear sequencer
//   walks every entry to zero (one per cycle), then the file reports ready.
//
// Parameters
//   DATA_W    data width per register
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   NUM_READ  number of read ports (1..4)
//   ZERO_REG  1: entry 0 reads as zero and ignores writes
//
// Ports
//   clk          rising-edge clock
//   resetIn      synchronous active-high reset
//   readAddr     packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   writeEnable  write strobe
//   writeAddr    write address
//   writeData    write data
//   resetOut     resetIn delayed one cycle
//   busy         high during reset and the clear sequence
//   readValid    readData holds the result for last cycle's addresses
//   readData     packed read data, port k = [k*DATA_W +: DATA_W]
//
// Handshake: readValid qualifies readData. There is no backpressure; while
//   ready, every edge launches a read for the presented addresses and the
//   result appears one cycle later with readValid=1.
//
// Build option
//   REGFILE_BYPASS_EN  defined: write-first (a same-edge write to a read
//                      address is forwarded to readData).
//                      undefined: read-first (pre-write value returned).
// -----------------------------------------------------------------------------
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         resetIn,
  input  logic [NUM_READ*ADDR_W-1:0]   readAddr,
  input  logic                         writeEnable,
  input  logic [ADDR_W-1:0]            writeAddr,
  input  logic [DATA_W-1:0]            writeData,
  output logic                         resetOut,
  output logic                         busy,
  output logic                         readValid,
  output logic [NUM_READ*DATA_W-1:0]   readData
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  // state is the observable sequencer state for checkers.
  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic                       wr_ok;
  logic [NUM_READ*DATA_W-1:0] rd_next;

  // Writes to entry 0 are discarded when it is the hardwired zero register.
  always_comb begin
    wr_ok = writeEnable;
    if ((ZERO_REG != 0) && (writeAddr == '0)) wr_ok = 1'b0;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    logic [DATA_W-1:0] val_k;

    assign addr_k = readAddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val_k = regs[addr_k];
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes entry 0 when it is hardwired.
      if (wr_ok && (writeAddr == addr_k)) val_k = writeData;
`endif
      if ((ZERO_REG != 0) && (addr_k == '0)) val_k = '0;
    end

    assign rd_next[k*DATA_W +: DATA_W] = val_k;
  end

  always_ff @(posedge clk) begin
    resetOut <= resetIn;
    if (resetIn) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      busy      <= 1'b1;
      readValid <= 1'b0;
      readData  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          // One entry per cycle; writes from WB are dropped here.
          regs[clr_ptr] <= '0;
          clr_ptr       <= clr_ptr + 1'b1;
          readValid     <= 1'b0;
          readData      <= '0;
          if (&clr_ptr) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (wr_ok) regs[writeAddr] <= writeData;
          readData  <= rd_next;
          readValid <= 1'b1;
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// -----------------------------------------------------------------------------
// tb_regfile_multiport
//   Directed bench for regfile_multiport (default parameters, 2 read ports).
//   Stimulus pushes the expected packed readData into exp_q on the edge that
//   launches the read; the monitor pops one entry per readValid cycle.
// -----------------------------------------------------------------------------
module tb_regfile_multiport;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_READ = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'h22;
`else
  localparam logic [31:0] COLL_EXP = 32'h11;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       resetIn;
  logic [NUM_READ*ADDR_W-1:0] readAddr;
  logic                       writeEnable;
  logic [ADDR_W-1:0]          writeAddr;
  logic [DATA_W-1:0]          writeData;
  logic                       resetOut;
  logic                       busy;
  logic                       readValid;
  logic [NUM_READ*DATA_W-1:0] readData;

  regfile_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ), .ZERO_REG(1)
  ) dut (
    .clk(clk), .resetIn(resetIn), .readAddr(readAddr),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .resetOut(resetOut), .busy(busy), .readValid(readValid), .readData(readData)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [NUM_READ*DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per valid read result.
  initial begin
    logic [NUM_READ*DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (readValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got 0x%0h, want no output (t=%0t)", readData, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", readData, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one cycle of inputs; if push, the read launched on this edge is
  // expected to return {e1,e0} one cycle later.
  task automatic cyc(input logic [4:0] a0, input logic [4:0] a1,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic push, input logic [31:0] e0, input logic [31:0] e1);
    readAddr    = {a1, a0};
    writeEnable = we;
    writeAddr   = wa;
    writeData   = wd;
    @(posedge clk);
    if (push) exp_q.push_back({e1, e0});
    #1;
  endtask

  // Runs clear cycles (resetIn already low) until busy drops, bounded.
  // A write to x1 is attempted at clear cycle index wr_at (none if < 0).
  task automatic clear_count(input int wr_at, output int n);
    n = 0;
    do begin
      cyc(5'd0, 5'd0, (n == wr_at), 5'd1, 32'h99, 1'b0, 32'h0, 32'h0);
      n++;
      if (n == 1) chk("resetOut_low", 64'(resetOut), 64'd0);
    end while (busy === 1'b1 && n < 100);
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy still high after %0d cycles, want low", n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    resetIn     = 1'b1;
    readAddr    = '0;
    writeEnable = 1'b0;
    writeAddr   = '0;
    writeData   = '0;

    // Reset state
    cyc(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst_resetOut", 64'(resetOut), 64'd1);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_readValid", 64'(readValid), 64'd0);
    chk("rst_readData", readData, 64'd0);
    cyc(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Clear takes exactly DEPTH cycles
    resetIn = 1'b0;
    clear_count(-1, n);
    chk("busy_cycles", 64'(n), 64'd32);

    // Every entry reads zero on both ports
    for (int i = 0; i < 32; i++)
      cyc(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);

    // Write/read x5
    cyc(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0);
    cyc(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);

    // x0 hardwired: same-edge read and later read both zero
    cyc(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 32'h0, 32'h0);
    cyc(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'hDEADBEEF);

    // Collision on port 1
    cyc(5'd0, 5'd0, 1'b1, 5'd7, 32'h11, 1'b1, 32'h0, 32'h0);
    cyc(5'd0, 5'd7, 1'b1, 5'd7, 32'h22, 1'b1, 32'h0, COLL_EXP);
    cyc(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 32'h22, 32'h22);

    // Dual ports, same and different addresses
    cyc(5'd0, 5'd0, 1'b1, 5'd3, 32'hA, 1'b1, 32'h0, 32'h0);
    cyc(5'd0, 5'd0, 1'b1, 5'd4, 32'hB, 1'b1, 32'h0, 32'h0);
    cyc(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA, 32'hB);
    cyc(5'd4, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 32'hB, 32'hB);

    // Reset mid-clear
    resetIn = 1'b1;
    cyc(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst2_busy", 64'(busy), 64'd1);
    chk("rst2_readValid", 64'(readValid), 64'd0);
    resetIn = 1'b0;
    for (int c = 1; c < 10; c++) begin
      cyc(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("clear_busy", 64'(busy), 64'd1);
    end
    resetIn = 1'b1;
    cyc(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst3_busy", 64'(busy), 64'd1);
    chk("rst3_resetOut", 64'(resetOut), 64'd1);
    resetIn = 1'b0;
    clear_count(5, n);
    chk("busy_cycles_restart", 64'(n), 64'd32);

    // Old contents cleared; write during clear dropped
    cyc(5'd1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);
    cyc(5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);
    cyc(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    chk("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
